// File: rtl/axis_axi_pkg.sv
// Shared definitions for the AXI-Stream to AXI4 write burst bridge.
// Holds the AXI burst/response encodings, the 4 KiB page size and the
// write-sequencer state type used by axis_axi_wr_burst_bridge.
package axis_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axis_axi_wr_fifo.sv
// Synchronous beat FIFO for the write bridge. Stores {tlast, tkeep, tdata}
// words; read data is presented from the head entry without a read strobe
// so the W channel can show it as soon as the burst starts.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en, wr_data     push one word (ignored when full)
//   rd_en, rd_data     pop the head word (ignored when empty), head data
//   count, full, empty occupancy status, all derived from registers
module axis_axi_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_axi_wr_burst_bridge.sv
// AXI-Stream sink to AXI4 master write bridge. Stream beats are buffered in
// a FIFO and written out as INCR bursts of up to MAX_BURST_LEN beats that
// never cross a 4 KiB page. The write address auto-advances after each
// burst; up to MAX_OUTSTANDING bursts may await their B response.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cfg_base_addr/_valid              start address load (only idle + FIFO empty)
//   s_axis_*                          stream input (tdata/tkeep/tlast)
//   m_axi_aw*, m_axi_w*, m_axi_b*     AXI4 write master channels
//   status_busy                       FIFO non-empty, burst active or B pending
//   status_outstanding                bursts awaiting a B response
//   status_err, status_err_count      only with AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN:
//                                     sticky error flag, saturating error count
//
// State | meaning
// IDLE  | waiting for a full burst or a pending tlast; length computed here
// AW    | awvalid high, address/length held until awready
// W     | streaming len FIFO beats, wlast on the final one
module axis_axi_wr_burst_bridge
    import axis_axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH/8,
    parameter int ADDR_WIDTH      = 34,
    parameter int ID_WIDTH        = 8,
    parameter int AXI_ID          = 0,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ADDR_WIDTH-1:0]                      cfg_base_addr,
    input  logic                                       cfg_base_addr_valid,
    input  logic [DATA_WIDTH-1:0]                      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                      s_axis_tkeep,
    input  logic                                       s_axis_tlast,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    output logic [ID_WIDTH-1:0]                        m_axi_awid,
    output logic [ADDR_WIDTH-1:0]                      m_axi_awaddr,
    output logic [7:0]                                 m_axi_awlen,
    output logic [2:0]                                 m_axi_awsize,
    output logic [1:0]                                 m_axi_awburst,
    output logic                                       m_axi_awlock,
    output logic [3:0]                                 m_axi_awcache,
    output logic [2:0]                                 m_axi_awprot,
    output logic                                       m_axi_awvalid,
    input  logic                                       m_axi_awready,
    output logic [DATA_WIDTH-1:0]                      m_axi_wdata,
    output logic [KEEP_WIDTH-1:0]                      m_axi_wstrb,
    output logic                                       m_axi_wlast,
    output logic                                       m_axi_wvalid,
    input  logic                                       m_axi_wready,
    input  logic [ID_WIDTH-1:0]                        m_axi_bid,
    input  logic [1:0]                                 m_axi_bresp,
    input  logic                                       m_axi_bvalid,
    output logic                                       m_axi_bready,
    output logic                                       status_busy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       status_outstanding
`ifdef AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN
    ,
    output logic                                       status_err,
    output logic [15:0]                                status_err_count
`endif
);

    localparam int SIZE_LOG2 = $clog2(KEEP_WIDTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH+1);
    localparam int LEN_W     = $clog2(MAX_BURST_LEN+1);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING+1);
    localparam int FIFO_W    = DATA_WIDTH + KEEP_WIDTH + 1;

    wr_state_t          state;
    wr_state_t          state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat_q;
    logic [OUT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      tlast_cnt_q;
    logic                  run_q;

    logic [FIFO_W-1:0]     fifo_rd_data;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  rd_tlast;

    logic [12:0]           page_bytes;
    logic [12:0]           page_beats;
    logic [15:0]           len_calc;
    logic                  burst_go;
    logic                  last_beat;
    logic                  aw_hs;
    logic                  b_hs;

    // run_q gates the ready outputs so they stay low through reset and rise
    // on the first cycle after it; tready depends on registers only.
    assign s_axis_tready = run_q && !fifo_full;
    assign m_axi_bready  = run_q;
    assign fifo_wr       = s_axis_tvalid && s_axis_tready;

    axis_axi_wr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {rd_tlast, m_axi_wstrb, m_axi_wdata} = fifo_rd_data;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(len_q - LEN_W'(1));
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;

    // Burst length: limited by FIFO occupancy, the burst cap and the beats
    // left before the next 4 KiB boundary.
    always_comb begin
        page_bytes = 13'(AXI_4K_BYTES) - {1'b0, addr_q[11:0]};
        page_beats = page_bytes >> SIZE_LOG2;
        len_calc   = 16'(MAX_BURST_LEN);
        if (16'(fifo_count) < len_calc) begin
            len_calc = 16'(fifo_count);
        end
        if (16'(page_beats) < len_calc) begin
            len_calc = 16'(page_beats);
        end
    end

    assign burst_go  = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && !fifo_empty &&
                       ((fifo_count >= CNT_W'(MAX_BURST_LEN)) || (tlast_cnt_q != '0));
    assign last_beat = (beat_q == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (burst_go)                  state_nxt = ST_AW;
            ST_AW:   if (m_axi_awready)             state_nxt = ST_W;
            ST_W:    if (m_axi_wready && last_beat) state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        case (state)
            ST_AW: m_axi_awvalid = 1'b1;
            ST_W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = last_beat;
            end
            default: ;
        endcase
    end

    assign fifo_rd = m_axi_wvalid && m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            outstanding_q <= '0;
            tlast_cnt_q   <= '0;
        end else begin
            run_q <= 1'b1;

            if (state == ST_IDLE && burst_go) begin
                len_q  <= LEN_W'(len_calc);
                beat_q <= '0;
            end else if (fifo_rd) begin
                beat_q <= beat_q + 1'b1;
            end

            // A base reload can only land between bursts with nothing
            // buffered, so it never splits a partially written stream.
            if (state == ST_IDLE && fifo_empty && cfg_base_addr_valid) begin
                addr_q <= cfg_base_addr;
            end else if (fifo_rd && last_beat) begin
                addr_q <= addr_q + (ADDR_WIDTH'(len_q) << SIZE_LOG2);
            end

            case ({aw_hs, b_hs})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: ;
            endcase

            case ({fifo_wr && s_axis_tlast, fifo_rd && rd_tlast})
                2'b10:   tlast_cnt_q <= tlast_cnt_q + 1'b1;
                2'b01:   tlast_cnt_q <= tlast_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign status_busy        = !fifo_empty || (state != ST_IDLE) || (outstanding_q != '0);
    assign status_outstanding = outstanding_q;

`ifdef AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            status_err       <= 1'b0;
            status_err_count <= '0;
        end else if (b_hs && m_axi_bresp != AXI_RESP_OKAY) begin
            status_err <= 1'b1;
            if (status_err_count != 16'hFFFF) begin
                status_err_count <= status_err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_axi_wr_burst_bridge.sv
module tb_axis_axi_wr_burst_bridge;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int AW  = 34;
    localparam int IDW = 8;
    localparam int FD  = 64;
    localparam int MBL = 16;
    localparam int MO  = 4;
    localparam int OW  = $clog2(MO+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   cfg_base_addr = '0;
    logic            cfg_base_addr_valid = 1'b0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [IDW-1:0]  m_axi_awid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready = 1'b0;
    logic [DW-1:0]   m_axi_wdata;
    logic [KW-1:0]   m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready = 1'b0;
    logic [IDW-1:0]  m_axi_bid = '0;
    logic [1:0]      m_axi_bresp = 2'b00;
    logic            m_axi_bvalid = 1'b0;
    logic            m_axi_bready;
    logic            status_busy;
    logic [OW-1:0]   status_outstanding;
`ifdef AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN
    logic            status_err;
    logic [15:0]     status_err_count;
`endif

    always #5 clk = ~clk;

    axis_axi_wr_burst_bridge #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .AXI_ID(0),
        .FIFO_DEPTH(FD), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_base_addr(cfg_base_addr), .cfg_base_addr_valid(cfg_base_addr_valid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .status_busy(status_busy), .status_outstanding(status_outstanding)
`ifdef AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN
        , .status_err(status_err), .status_err_count(status_err_count)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;

    beat_t exp_beats[$];
    aw_t   exp_aw[$];
    aw_t   act_aw[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] model_addr = '0;
    int  beats_sent = 0;
    int  aw_hs      = 0;
    int  w_done     = 0;
    int  b_hs       = 0;
    bit  aw_exact   = 1'b1;
    bit  ready_rand = 1'b0;
    bit  b_en       = 1'b1;
    bit  b_rand     = 1'b0;
    int  err_idx    = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, expected event", what);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Called on a negedge; tready at this point is what the DUT sees on the
    // following posedge, since it depends on registered state only.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int t;
        t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!s_axis_tready) begin
            @(negedge clk);
            t++;
            if (t > 2000) timeout_fail("stream_accept");
        end
        exp_beats.push_back('{model_addr, d, k});
        model_addr = model_addr + AW'(KW);
        beats_sent++;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit last_on_end, input bit rnd);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                k = KW'($urandom);
                l = ($urandom_range(0, 9) == 0);
            end else begin
                k = '1;
                l = 1'b0;
            end
            d = {$urandom, $urandom};
            if (i == n - 1 && last_on_end) l = 1'b1;
            send_beat(d, k, l);
        end
    endtask

    task automatic wait_idle(input string what);
        int t;
        t = 0;
        while (status_busy || exp_beats.size() != 0 || b_hs != w_done) begin
            @(negedge clk);
            t++;
            if (t > 5000) timeout_fail(what);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_base(input logic [AW-1:0] a);
        wait_idle("idle_before_load");
        cfg_base_addr       = a;
        cfg_base_addr_valid = 1'b1;
        @(negedge clk);
        cfg_base_addr_valid = 1'b0;
        model_addr          = a;
    endtask

    // AXI ready generator
    initial begin
        forever begin
            @(negedge clk);
            m_axi_awready = !ready_rand || ($urandom_range(0, 3) != 0);
            m_axi_wready  = !ready_rand || ($urandom_range(0, 3) != 0);
        end
    end

    // B responder: one response per completed burst
    initial begin
        forever begin
            @(negedge clk);
            m_axi_bvalid = b_en && (w_done > b_hs) && (!b_rand || $urandom_range(0, 2) == 0);
            m_axi_bresp  = (b_hs == err_idx) ? 2'b10 : 2'b00;
            #1;
            if (!rst && m_axi_bvalid && m_axi_bready) b_hs++;
        end
    end

    // AW monitor
    initial begin
        aw_t e;
        logic [AW-1:0] p_addr;
        logic [7:0]    p_len;
        bit            p_stall;
        p_stall = 1'b0;
        p_addr  = '0;
        p_len   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && m_axi_awvalid) begin
                if (p_stall) begin
                    check("aw_hold_addr", 64'(m_axi_awaddr), 64'(p_addr));
                    check("aw_hold_len", 64'(m_axi_awlen), 64'(p_len));
                end
                p_stall = !m_axi_awready;
                p_addr  = m_axi_awaddr;
                p_len   = m_axi_awlen;
            end else begin
                p_stall = 1'b0;
            end
            if (!rst && m_axi_awvalid && m_axi_awready) begin
                aw_hs++;
                check("aw_attrs",
                      64'({m_axi_awsize, m_axi_awburst, m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot}),
                      64'({3'd3, 2'd1, 8'd0, 1'b0, 4'd0, 3'd0}));
                check("aw_len_cap", 64'(m_axi_awlen <= 8'(MBL - 1)), 64'd1);
                check("aw_4k", 64'((int'(m_axi_awaddr[11:0]) + (int'(m_axi_awlen) + 1) * KW) <= 4096), 64'd1);
                act_aw.push_back('{m_axi_awaddr, m_axi_awlen});
                if (exp_aw.size() != 0) begin
                    e = exp_aw.pop_front();
                    check("aw_addr", 64'(m_axi_awaddr), 64'(e.addr));
                    check("aw_len", 64'(m_axi_awlen), 64'(e.len));
                end else if (aw_exact) begin
                    check("aw_unexpected", 64'(m_axi_awaddr), 64'h0);
                end
            end
        end
    end

    // W monitor / scoreboard
    initial begin
        aw_t           cur;
        beat_t         e;
        int            w_beat;
        logic [AW-1:0] a;
        w_beat = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && m_axi_wvalid && m_axi_wready) begin
                if (act_aw.size() == 0 || exp_beats.size() == 0) begin
                    check("w_without_aw_or_data", 64'(act_aw.size()), 64'(exp_beats.size() + 1));
                end else begin
                    cur = act_aw[0];
                    e   = exp_beats.pop_front();
                    a   = cur.addr + AW'(w_beat * KW);
                    check("w_addr", 64'(a), 64'(e.addr));
                    check("w_data", m_axi_wdata, e.data);
                    check("w_strb", 64'(m_axi_wstrb), 64'(e.keep));
                    check("w_last", 64'(m_axi_wlast), 64'(w_beat == int'(cur.len)));
                    w_beat++;
                    if (w_beat > int'(cur.len)) begin
                        void'(act_aw.pop_front());
                        w_beat = 0;
                        w_done++;
                    end
                end
            end
        end
    end

    initial begin
        int aw0;
        int bs0;
        int t;
        int inj;
        logic [AW-1:0] base;

        repeat (3) @(negedge clk);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_bready", 64'(m_axi_bready), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_outstanding", 64'(status_outstanding), 64'd0);
        check("rst_busy", 64'(status_busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_bready", 64'(m_axi_bready), 64'd1);
        check("post_rst_tready", 64'(s_axis_tready), 64'd1);

        // Two full bursts, 8 beats left buffered
        aw_exact = 1'b1;
        load_base(34'h1000);
        aw0 = aw_hs;
        exp_aw.push_back('{34'h1000, 8'd15});
        exp_aw.push_back('{34'h1080, 8'd15});
        send_stream(40, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check("c1_aw_count", 64'(aw_hs - aw0), 64'd2);
        check("c1_held_beats", 64'(exp_beats.size()), 64'd8);
        check("c1_busy", 64'(status_busy), 64'd1);
        exp_aw.push_back('{34'h1100, 8'd8});
        send_stream(1, 1'b1, 1'b0);
        wait_idle("c1_flush");

        // tlast-terminated short burst, then address continuation
        load_base(34'h2000);
        exp_aw.push_back('{34'h2000, 8'd4});
        send_stream(5, 1'b1, 1'b0);
        wait_idle("c2_burst");
        exp_aw.push_back('{34'h2028, 8'd0});
        send_stream(1, 1'b1, 1'b0);
        wait_idle("c2_next");

        // 4 KiB split
        load_base(34'h0FC0);
        exp_aw.push_back('{34'h0FC0, 8'd7});
        exp_aw.push_back('{34'h1000, 8'd7});
        send_stream(16, 1'b1, 1'b0);
        wait_idle("c3_split");
        check("c3_exp_aw_drained", 64'(exp_aw.size()), 64'd0);

        // Outstanding limit with B held off
        aw_exact = 1'b0;
        load_base(34'h5000);
        b_en = 1'b0;
        aw0  = aw_hs;
        bs0  = beats_sent;
        fork
            send_stream(140, 1'b1, 1'b0);
            begin
                t = 0;
                while (aw_hs - aw0 < 4) begin
                    @(negedge clk);
                    t++;
                    if (t > 2000) timeout_fail("c4_four_aw");
                end
                repeat (150) @(negedge clk);
                check("c4_aw_count", 64'(aw_hs - aw0), 64'd4);
                check("c4_outstanding", 64'(status_outstanding), 64'd4);
                check("c4_tready_low", 64'(s_axis_tready), 64'd0);
                check("c4_accepted", 64'(beats_sent - bs0), 64'd128);
                b_en = 1'b1;
            end
        join
        wait_idle("c4_resume");
        check("c4_all_beats", 64'(beats_sent - bs0), 64'd140);
        check("c4_outstanding_end", 64'(status_outstanding), 64'd0);

        // Randomized traffic with ignored mid-burst reloads
        ready_rand = 1'b1;
        b_rand     = 1'b1;
        for (int r = 0; r < 3; r++) begin
            base = {2'($urandom), 20'($urandom), 12'h000};
            base[11:0] = 12'hC00 + 12'($urandom_range(0, 127) * KW);
            load_base(base);
            inj = 0;
            fork
                send_stream(150, 1'b1, 1'b1);
                begin
                    for (int c = 0; c < 600 && inj < 3; c++) begin
                        @(negedge clk);
                        if (m_axi_wvalid && $urandom_range(0, 7) == 0) begin
                            cfg_base_addr       = {2'($urandom), 32'($urandom)} & ~AW'(7);
                            cfg_base_addr_valid = 1'b1;
                            @(negedge clk);
                            cfg_base_addr_valid = 1'b0;
                            inj++;
                        end
                    end
                end
            join
            wait_idle("rand_drain");
            check("rand_beats_left", 64'(exp_beats.size()), 64'd0);
            check("rand_outstanding", 64'(status_outstanding), 64'd0);
        end
        ready_rand = 1'b0;
        b_rand     = 1'b0;

`ifdef AXIS_AXI_WR_BURST_BRIDGE_BRESP_CHECK_EN
        load_base(34'h8000);
        err_idx = b_hs + 1;
        send_stream(48, 1'b1, 1'b0);
        wait_idle("err_bursts");
        check("err_flag", 64'(status_err), 64'd1);
        check("err_count", 64'(status_err_count), 64'd1);
        repeat (10) @(negedge clk);
        check("err_sticky", 64'(status_err), 64'd1);
        err_idx = -1;
        rst = 1'b1;
        @(negedge clk);
        check("err_rst_flag", 64'(status_err), 64'd0);
        check("err_rst_count", 64'(status_err_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
